aes256_key_schedule: RTL and testbench
======================================

# aes256_key_schedule

Sequential AES-256 key-schedule engine for the decryption datapath. It loads a 256-bit cipher key, iterates the existing combinational `keyExpansion` stage once per clock, and stores all 15 128-bit round keys in an internal register file. The decryption round controller then reads the keys by round number, in encrypt order or reversed decrypt order.

## Interface

Parameters: none; all widths are fixed by AES-256.

Ports (clock and reset first):
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: load `key_in` and begin expansion. Sampled only in IDLE or DONE.
- `key_in` input, 256 bits: cipher key, with w0 in [255:224]. Sampled on the same edge as `start`.
- `busy` output, 1 bit: high while the state is EXPAND.
- `keys_valid` output, 1 bit: high in DONE; all 15 round keys are stored and stable.
- `rd_en` input, 1 bit: read request.
- `rd_round` input, 4 bits: round index, 0 to 14.
- `rd_dec` input, 1 bit: 1 selects physical address 14−`rd_round`; 0 selects `rd_round`.
- `rd_key` output, 128 bits: registered read data.
- `rd_valid` output, 1 bit: registered read strobe.

## Operation

State machine: IDLE → EXPAND → DONE.
- **IDLE**
  - On `start`: `key_reg` ← `key_in`.
  - rk[0] ← key_in[255:128] and rk[1] ← key_in[127:0].
  - `rc` ← 0; go to EXPAND.
- **EXPAND**, one cycle per `rc` value 0 to 6:
  - `keyout` = keyExpansion(`rc`, `key_reg`); `key_reg` ← `keyout`.
  - rk[2+2·rc] ← keyout[255:128].
  - rk[3+2·rc] ← keyout[127:0], except when rc=6: that write would be rk[15], which does not exist and is discarded.
  - `rc` increments each cycle. The cycle with rc=6 transitions to DONE.
- **DONE**: hold until the next `start`. A `start` restarts exactly as from IDLE; `keys_valid` drops on that same edge.
- `start` during EXPAND is ignored. There is no queuing.
- Storage: 15 entries × 128 bits, register file, no reset of contents required. Contents are undefined until the first completed expansion.
- Reads: on an edge with `rd_en`=1, compute addr = `rd_dec` ? 14−`rd_round` : `rd_round`.
  - If `keys_valid`=1 and `rd_round` ≤ 14: `rd_key` ← rk[addr], `rd_valid` ← 1.
  - Otherwise: `rd_key` ← 0, `rd_valid` ← 0.
  - With `rd_en`=0: `rd_valid` ← 0 and `rd_key` holds its value.
- A read on the same edge as `start` in DONE is served from the old keys. `keys_valid` is still 1 when that edge is sampled.

## Timing

- Reset values: state IDLE, `rc`=0, `key_reg`=0, `busy`=0, `keys_valid`=0, `rd_valid`=0, `rd_key`=0.
- Key-load latency: if `start` is sampled at edge E, then:
  - `busy`=1 after E.
  - Expansions occur at E+1 … E+7.
  - `keys_valid`=1 and `busy`=0 after E+7. Total: 8 cycles, start to valid.
- Read latency: 1 cycle from the edge that samples `rd_en` to `rd_key`/`rd_valid`. Back-to-back reads are accepted every cycle.
- Reset asserted mid-EXPAND: return to IDLE immediately and clear `keys_valid`. Partially written keys are never reported valid.
- Critical path: `key_reg` → keyExpansion (two serial S-box layers) → `key_reg`. No pipelining inside an iteration.

## Structure

- The shared `aes_pkg` package holds:
  - `AES256_NUM_RK` = 15
  - `AES_RK_W` = 128
  - `AES256_KEY_W` = 256
  - `AES256_EXP_STEPS` = 7
  - the state enum `ks_state_t` {IDLE, EXPAND, DONE}
- One sub-module: a single existing `keyExpansion` instance, with its `sbox` instances, driven by `rc` and `key_reg`.
- FSM, `rc` counter, register file and read port live in this module.

## Test plan

- **FIPS-197 load:** pulse `start` with key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - `keys_valid` rises 8 cycles after `start`.
  - Read round 2 (`rd_dec`=0) → 9ba354118e6925afa51a8b5f2067fcde.
  - Read round 14 → fe4890d1e6188d0b046df344706c631e.
- **Decrypt order:** key 000102…1f, `rd_dec`=1.
  - `rd_round`=0 → 24fc79ccbf0979e9371ac23c6d68de36.
  - `rd_round`=14 → 000102030405060708090a0b0c0d0e0f.
- **Guarded read:** `rd_en` before `keys_valid`, or with `rd_round`=15 → `rd_valid`=0 and `rd_key`=0 on the following cycle.
- **Ignored restart:** `start` with a second key at expansion cycle 3.
  - Sequence unchanged; `keys_valid` arrives on schedule with the first key's values.
  - A subsequent `start` in DONE drops `keys_valid`, then yields the second key's schedule after 8 cycles.
- **Reset mid-expansion:** assert `rst` asynchronously at expansion cycle 4.
  - All outputs zero immediately; state IDLE.
  - A fresh `start` produces a correct full schedule.
- **Streaming reads:** 15 consecutive `rd_en` cycles, rounds 0 to 14 → 15 consecutive `rd_valid` pulses, each matching the reference vectors, one cycle delayed.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES widths, key-schedule FSM state type and round constant.
package aes_pkg;
   localparam int AES256_NUM_RK    = 15;
   localparam int AES_RK_W         = 128;
   localparam int AES256_KEY_W     = 256;
   localparam int AES256_EXP_STEPS = 7;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      DONE
   } ks_state_t;

   function automatic logic [7:0] rcon(input logic [2:0] rc);
      return 8'h01 << rc;
   endfunction
endpackage

// File: rtl/aes256_key_schedule_if.sv
// Control, key-load and round-key read signals of the key-schedule engine.
interface aes256_key_schedule_if;
   import aes_pkg::*;

   logic                    start;
   logic [AES256_KEY_W-1:0] key_in;
   logic                    busy;
   logic                    keys_valid;
   logic                    rd_en;
   logic [3:0]              rd_round;
   logic                    rd_dec;
   logic [AES_RK_W-1:0]     rd_key;
   logic                    rd_valid;

   modport master (
      output start, key_in, rd_en, rd_round, rd_dec,
      input  busy, keys_valid, rd_key, rd_valid
   );

   modport slave (
      input  start, key_in, rd_en, rd_round, rd_dec,
      output busy, keys_valid, rd_key, rd_valid
   );
endinterface

// File: rtl/keyExpansion.sv
// One AES-256 expansion step: eight new words from the previous eight.
module keyExpansion
   import aes_pkg::*;
(
   input  logic [2:0]              rc,
   input  logic [AES256_KEY_W-1:0] keyin,
   output logic [AES256_KEY_W-1:0] keyout
);
   logic [31:0] w [8];
   logic [31:0] t [8];
   logic [31:0] rot;
   logic [31:0] sub1;
   logic [31:0] sub2;

   for (genvar gi = 0; gi < 8; gi++) begin : g_w
      assign w[gi] = keyin[255-32*gi -: 32];
   end

   assign rot = {w[7][23:0], w[7][31:24]};

   // Two serial S-box layers: RotWord/SubWord, then SubWord on t[3].
   for (genvar gj = 0; gj < 4; gj++) begin : g_sb
      sbox u_s1 (.a(rot[8*gj +: 8]),  .y(sub1[8*gj +: 8]));
      sbox u_s2 (.a(t[3][8*gj +: 8]), .y(sub2[8*gj +: 8]));
   end

   assign t[0] = w[0] ^ sub1 ^ {rcon(rc), 24'h0};
   assign t[1] = w[1] ^ t[0];
   assign t[2] = w[2] ^ t[1];
   assign t[3] = w[3] ^ t[2];
   assign t[4] = w[4] ^ sub2;
   assign t[5] = w[5] ^ t[4];
   assign t[6] = w[6] ^ t[5];
   assign t[7] = w[7] ^ t[6];

   assign keyout = {t[0], t[1], t[2], t[3],
                    t[4], t[5], t[6], t[7]};
endmodule

// File: rtl/sbox.sv
// AES forward S-box, table lookup; byte i sits at TBL[8*(255-i) +: 8].
module sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [2047:0] TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign y = TBL[{~a, 3'b000} +: 8];
endmodule

// File: rtl/aes256_key_schedule.sv
// Sequential AES-256 key schedule: one expansion step per clock into a
// 15-entry round-key file, read by round in encrypt or decrypt order.
module aes256_key_schedule
   import aes_pkg::*;
(
   input logic clk,
   input logic rst,
   aes256_key_schedule_if.slave ks
);
   ks_state_t               state;
   ks_state_t               nstate;
   logic [2:0]              rc;
   logic [AES256_KEY_W-1:0] key_reg;
   logic [AES256_KEY_W-1:0] keyout;
   logic [AES_RK_W-1:0]     rk [AES256_NUM_RK];

   logic       load;
   logic       step;
   logic       last;
   logic [3:0] hi_addr;
   logic [3:0] lo_addr;
   logic [3:0] rd_addr;
   logic       rd_ok;

   keyExpansion u_kexp (
      .rc     (rc),
      .keyin  (key_reg),
      .keyout (keyout)
   );

   assign load = ks.start && (state != EXPAND);
   assign step = (state == EXPAND);
   assign last = step && (rc == 3'(AES256_EXP_STEPS - 1));

   assign ks.busy       = (state == EXPAND);
   assign ks.keys_valid = (state == DONE);

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:    if (ks.start) nstate = EXPAND;
         EXPAND:  if (last)     nstate = DONE;
         DONE:    if (ks.start) nstate = EXPAND;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rc      <= '0;
         key_reg <= '0;
      end else begin
         state <= nstate;
         if (load) begin
            rc      <= '0;
            key_reg <= ks.key_in;
         end else if (step) begin
            rc      <= rc + 3'd1;
            key_reg <= keyout;
         end
      end
   end

   assign hi_addr = {rc, 1'b0} + 4'd2;
   assign lo_addr = hi_addr + 4'd1;

   // Last step would write a 16th entry; its low half is dropped.
   always_ff @(posedge clk) begin
      if (load) begin
         rk[0] <= ks.key_in[255:128];
         rk[1] <= ks.key_in[127:0];
      end else if (step) begin
         rk[hi_addr] <= keyout[255:128];
         if (!last) rk[lo_addr] <= keyout[127:0];
      end
   end

   assign rd_addr = ks.rd_dec ? (4'd14 - ks.rd_round) : ks.rd_round;
   assign rd_ok   = ks.keys_valid && (ks.rd_round <= 4'd14);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ks.rd_key   <= '0;
         ks.rd_valid <= 1'b0;
      end else if (ks.rd_en) begin
         if (rd_ok) begin
            ks.rd_key   <= rk[rd_addr];
            ks.rd_valid <= 1'b1;
         end else begin
            ks.rd_key   <= '0;
            ks.rd_valid <= 1'b0;
         end
      end else begin
         ks.rd_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_aes256_key_schedule.sv
// Scoreboard bench for aes256_key_schedule with FIPS-197 vectors and an
// algebraic (GF inverse + affine) reference expansion.
module tb_aes256_key_schedule;
   import aes_pkg::*;

   localparam logic [255:0] K1 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] K2 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   typedef struct {
      logic         v;
      logic [127:0] k;
      string        name;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic req_d = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb [$];
   logic [127:0] ref_rk [2][15];

   aes256_key_schedule_if ifc ();

   aes256_key_schedule dut (
      .clk (clk),
      .rst (rst),
      .ks  (ifc)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] b = 8'h01;
      for (int i = 0; i < 254; i++) b = gmul(b, x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^
             {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sbox_ref(x[31:24]), sbox_ref(x[23:16]),
              sbox_ref(x[15:8]),  sbox_ref(x[7:0])};
   endfunction

   task automatic compute_ref(input logic [255:0] k, input int which);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rcb;
      for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            rcb = 8'h01 << (i / 8 - 1);
            t = subw({t[23:0], t[31:24]}) ^ {rcb, 24'h0};
         end else if (i % 8 == 4) begin
            t = subw(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int r = 0; r < 15; r++)
         ref_rk[which][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [255:0] act,
                      input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) req_d <= ifc.rd_en;

   always @(negedge clk) begin
      exp_t e;
      if (req_d) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL read with empty scoreboard: rd_valid=%b", ifc.rd_valid);
         end else begin
            e = sb.pop_front();
            if (ifc.rd_valid !== e.v || ifc.rd_key !== e.k) begin
               miscompares++;
               $display("FAIL %s: got v=%b key=%h expected v=%b key=%h",
                        e.name, ifc.rd_valid, ifc.rd_key, e.v, e.k);
            end
         end
      end else if (ifc.rd_valid !== 1'b0) begin
         vectors++;
         miscompares++;
         $display("FAIL spurious rd_valid: got %b expected 0", ifc.rd_valid);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int r, input logic dec, input logic v,
                     input logic [127:0] k, input string name);
      exp_t e;
      ifc.rd_en    = 1'b1;
      ifc.rd_round = 4'(r);
      ifc.rd_dec   = dec;
      e.v = v;
      e.k = k;
      e.name = name;
      sb.push_back(e);
      tick();
      ifc.rd_en = 1'b0;
   endtask

   task automatic do_start(input logic [255:0] k);
      ifc.start  = 1'b1;
      ifc.key_in = k;
      tick();
      ifc.start = 1'b0;
      chk("busy after start", 256'(ifc.busy), 256'(1));
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!ifc.keys_valid && n < 20) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      compute_ref(K1, 0);
      compute_ref(K2, 1);
      rst          = 1'b1;
      ifc.start    = 1'b0;
      ifc.key_in   = '0;
      ifc.rd_en    = 1'b0;
      ifc.rd_round = '0;
      ifc.rd_dec   = 1'b0;
      tick();
      chk("reset busy",       256'(ifc.busy),       256'(0));
      chk("reset keys_valid", 256'(ifc.keys_valid), 256'(0));
      chk("reset rd_valid",   256'(ifc.rd_valid),   256'(0));
      chk("reset rd_key",     256'(ifc.rd_key),     256'(0));
      tick();
      rst = 1'b0;
      tick();

      rd(2, 1'b0, 1'b0, '0, "read before valid");

      // FIPS-197 load
      do_start(K1);
      wait_valid(n);
      chk("load latency", 256'(n), 256'(7));
      chk("busy at done", 256'(ifc.busy), 256'(0));
      rd(2,  1'b0, 1'b1, 128'h9ba354118e6925afa51a8b5f2067fcde, "fips round 2");
      rd(14, 1'b0, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e, "fips round 14");
      rd(15, 1'b0, 1'b0, '0, "round 15 enc");
      rd(15, 1'b1, 1'b0, '0, "round 15 dec");
      for (int r = 0; r < 15; r++)
         rd(r, 1'b0, 1'b1, ref_rk[0][r], $sformatf("stream k1 r%0d", r));

      // Decrypt order
      do_start(K2);
      wait_valid(n);
      chk("k2 latency", 256'(n), 256'(7));
      rd(0,  1'b1, 1'b1, 128'h24fc79ccbf0979e9371ac23c6d68de36, "dec round 0");
      rd(14, 1'b1, 1'b1, 128'h000102030405060708090a0b0c0d0e0f, "dec round 14");
      for (int r = 0; r < 15; r++)
         rd(r, 1'b1, 1'b1, ref_rk[1][14-r], $sformatf("stream dec r%0d", r));

      // Ignored restart during expansion
      do_start(K1);
      tick();
      tick();
      ifc.start  = 1'b1;
      ifc.key_in = K2;
      tick();
      ifc.start = 1'b0;
      chk("busy after ignored start", 256'(ifc.busy), 256'(1));
      wait_valid(n);
      chk("restart latency", 256'(n + 3), 256'(7));
      rd(14, 1'b0, 1'b1, ref_rk[0][14], "after ignored start r14");
      rd(3,  1'b0, 1'b1, ref_rk[0][3],  "after ignored start r3");

      // Start in DONE with a same-edge read served from old keys
      begin
         exp_t e;
         ifc.start    = 1'b1;
         ifc.key_in   = K2;
         ifc.rd_en    = 1'b1;
         ifc.rd_round = 4'd2;
         ifc.rd_dec   = 1'b0;
         e.v = 1'b1;
         e.k = 128'h9ba354118e6925afa51a8b5f2067fcde;
         e.name = "read on restart edge";
         sb.push_back(e);
         tick();
         ifc.start = 1'b0;
         ifc.rd_en = 1'b0;
      end
      chk("keys_valid drops on restart", 256'(ifc.keys_valid), 256'(0));
      wait_valid(n);
      chk("second key latency", 256'(n + 1), 256'(8));
      rd(0, 1'b1, 1'b1, 128'h24fc79ccbf0979e9371ac23c6d68de36, "second key dec 0");

      // Reset mid-expansion
      do_start(K1);
      repeat (4) tick();
      #2;
      rst = 1'b1;
      #1;
      chk("mid rst busy",       256'(ifc.busy),       256'(0));
      chk("mid rst keys_valid", 256'(ifc.keys_valid), 256'(0));
      chk("mid rst rd_valid",   256'(ifc.rd_valid),   256'(0));
      chk("mid rst rd_key",     256'(ifc.rd_key),     256'(0));
      tick();
      rst = 1'b0;
      repeat (2) tick();
      chk("idle after rst", 256'(ifc.busy), 256'(0));
      rd(1, 1'b0, 1'b0, '0, "read after rst");
      do_start(K2);
      wait_valid(n);
      chk("post-rst latency", 256'(n), 256'(7));
      for (int r = 0; r < 15; r++)
         rd(r, 1'b0, 1'b1, ref_rk[1][r], $sformatf("stream k2 r%0d", r));

      repeat (3) tick();
      chk("scoreboard drained", 256'(sb.size()), 256'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end
endmodule
